// File: rtl/reset_seq.sv
// Reset sequencer: stages bus and CPU reset release after the chip reset, with an optional
// software reset path built only when RESET_SEQ_SWRST_EN is defined.
module reset_seq #(
  parameter int STABLE_CYCLES  = 256,
  parameter int STAGE_GAP      = 4,
  parameter int SW_HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_reset_req,
  output logic       bus_reset,
  output logic       cpu_reset,
  output logic       sys_ready,
  output logic [1:0] rst_cause
);

  localparam int MAX_AB = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_P  = (MAX_AB > SW_HOLD_CYCLES) ? MAX_AB : SW_HOLD_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_BUS_REL,
    ST_RUN,
    ST_SW_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             syncRst;
  logic             busReset_q, busReset_d;
  logic             cpuReset_q, cpuReset_d;
  logic             sysReady_q, sysReady_d;

  // Set asynchronously by the chip reset, released two edges after it falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign syncRst = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      busReset_q <= 1'b1;
      cpuReset_q <= 1'b1;
      sysReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busReset_q <= busReset_d;
      cpuReset_q <= cpuReset_d;
      sysReady_q <= sysReady_d;
    end
  end

  // The counter is cleared on every state entry, so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (!syncRst) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == STABLE_LAST) begin
          state_d = ST_BUS_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BUS_REL: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
`ifdef RESET_SEQ_SWRST_EN
        if (sw_reset_req) begin
          state_d = ST_SW_HOLD;
          cnt_d   = '0;
        end
`endif
      end
`ifdef RESET_SEQ_SWRST_EN
      ST_SW_HOLD: begin
        if (cnt_q == SW_LAST) begin
          state_d = ST_BUS_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on the transition edge.
  always_comb begin
    busReset_d = 1'b1;
    cpuReset_d = 1'b1;
    sysReady_d = 1'b0;
    case (state_d)
      ST_BUS_REL: begin
        busReset_d = 1'b0;
      end
      ST_RUN: begin
        busReset_d = 1'b0;
        cpuReset_d = 1'b0;
        sysReady_d = 1'b1;
      end
      default: begin
        busReset_d = 1'b1;
      end
    endcase
  end

`ifdef RESET_SEQ_SWRST_EN
  logic [1:0] rstCause_q, rstCause_d;

  always_comb begin
    rstCause_d = rstCause_q;
    if (state_q == ST_RUN && state_d == ST_SW_HOLD) begin
      rstCause_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstCause_q <= 2'b01;
    end else begin
      rstCause_q <= rstCause_d;
    end
  end

  assign rst_cause = rstCause_q;
`else
  logic unusedSwReq;
  assign unusedSwReq = sw_reset_req;
  assign rst_cause   = 2'b01;
`endif

  assign bus_reset = busReset_q;
  assign cpu_reset = cpuReset_q;
  assign sys_ready = sysReady_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: power-up vector table, hand-written corner sequences and random
// stimulus compared every edge against an edge-counting reference model.
module tb_reset_seq;

  localparam int S = 8;
  localparam int G = 4;
  localparam int H = 3;

`ifdef RESET_SEQ_SWRST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       swReq = 1'b0;
  logic       busRst, cpuRst, sysReady;
  logic [1:0] rstCause;

  int errors = 0;
  int checks = 0;

  // Reference model: edges since reset fell (mK) or since a software request was accepted (mJ).
  bit         mSw;
  int         mK, mJ;
  logic       mBus, mCpu, mReady;
  logic [1:0] mCause;
  int         edgeNo;

  typedef struct {
    int         edgeNo;
    logic       req;
    logic       bus;
    logic       cpu;
    logic       ready;
    logic [1:0] cause;
  } vec_t;

  vec_t powerUp [6];

  reset_seq #(
    .STABLE_CYCLES (S),
    .STAGE_GAP     (G),
    .SW_HOLD_CYCLES(H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_reset_req(swReq),
    .bus_reset   (busRst),
    .cpu_reset   (cpuRst),
    .sys_ready   (sysReady),
    .rst_cause   (rstCause)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic b, input logic c, input logic r,
                             input logic [1:0] ca);
    checks++;
    if ({busRst, cpuRst, sysReady, rstCause} !== {b, c, r, ca}) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got bus=%b cpu=%b ready=%b cause=%b, want bus=%b cpu=%b ready=%b cause=%b",
               name, edgeNo, busRst, cpuRst, sysReady, rstCause, b, c, r, ca);
    end
  endtask

  task automatic modelReset();
    mSw    = 1'b0;
    mK     = 0;
    mJ     = 0;
    mCause = 2'b01;
    mBus   = 1'b1;
    mCpu   = 1'b1;
    mReady = 1'b0;
    edgeNo = 0;
  endtask

  // One clock edge: advance the model from the sampled inputs, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      edgeNo++;
      if (SW_EN && !mCpu && swReq) begin
        mSw    = 1'b1;
        mJ     = 0;
        mCause = 2'b10;
      end else if (mSw) begin
        mJ++;
      end else begin
        mK++;
      end
      if (mSw) begin
        mBus = (mJ < H);
        mCpu = (mJ < H + G);
      end else begin
        mBus = (mK < S + 3);
        mCpu = (mK < S + 3 + G);
      end
      mReady = ~mCpu;
    end
    #1;
    checkOutput("model", mBus, mCpu, mReady, mCause);
  endtask

  // Reset is asserted mid-cycle (checked immediately) and released on a falling clock edge.
  task automatic applyStimulus(input logic rstV, input logic reqV);
    swReq = reqV;
    if (rstV && !reset) begin
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("asyncAssert", 1'b1, 1'b1, 1'b0, 2'b01);
    end else if (!rstV && reset) begin
      @(negedge clk);
      reset  = 1'b0;
      edgeNo = 0;
    end
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < 6; i++) begin
      swReq = powerUp[i].req;
      while (edgeNo < powerUp[i].edgeNo) tick();
      checkOutput(name, powerUp[i].bus, powerUp[i].cpu, powerUp[i].ready, powerUp[i].cause);
    end
  endtask

  initial begin
    powerUp[0] = '{edgeNo: 1,  req: 1'b0, bus: 1'b1, cpu: 1'b1, ready: 1'b0, cause: 2'b01};
    powerUp[1] = '{edgeNo: 10, req: 1'b0, bus: 1'b1, cpu: 1'b1, ready: 1'b0, cause: 2'b01};
    powerUp[2] = '{edgeNo: 11, req: 1'b0, bus: 1'b0, cpu: 1'b1, ready: 1'b0, cause: 2'b01};
    powerUp[3] = '{edgeNo: 14, req: 1'b0, bus: 1'b0, cpu: 1'b1, ready: 1'b0, cause: 2'b01};
    powerUp[4] = '{edgeNo: 15, req: 1'b0, bus: 1'b0, cpu: 1'b0, ready: 1'b1, cause: 2'b01};
    powerUp[5] = '{edgeNo: 18, req: 1'b0, bus: 1'b0, cpu: 1'b0, ready: 1'b1, cause: 2'b01};

    modelReset();
    #1 reset = 1'b1;
    repeat (5) tick();
    checkOutput("resetState", 1'b1, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0);
    runTable("powerUp");

    // Abort in the middle of WAIT, then the full sequence restarts.
    applyStimulus(1'b1, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0);
    while (edgeNo < 6) tick();
    applyStimulus(1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("abortHold", 1'b1, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0);
    runTable("abortRestart");

    // Single-cycle software request in RUN.
    swReq = 1'b1;
    tick();
    swReq = 1'b0;
    checkOutput("swAssert", SW_EN, SW_EN, ~SW_EN, SW_EN ? 2'b10 : 2'b01);
    repeat (3) tick();
    checkOutput("swBusRel", 1'b0, SW_EN, ~SW_EN, SW_EN ? 2'b10 : 2'b01);
    repeat (4) tick();
    checkOutput("swCpuRel", 1'b0, 1'b0, 1'b1, SW_EN ? 2'b10 : 2'b01);

    // Request held from WAIT through RUN entry: first RUN edge accepts, SW_HOLD does not retrigger.
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    while (edgeNo < 5) tick();
    swReq = 1'b1;
    while (edgeNo < 15) tick();
    checkOutput("heldIgnored", 1'b0, 1'b0, 1'b1, 2'b01);
    tick();
    checkOutput("heldAccept", SW_EN, SW_EN, ~SW_EN, SW_EN ? 2'b10 : 2'b01);
    repeat (3) tick();
    checkOutput("heldNoRetrig", 1'b0, SW_EN, ~SW_EN, SW_EN ? 2'b10 : 2'b01);
    swReq = 1'b0;
    repeat (4) tick();
    checkOutput("heldRun", 1'b0, 1'b0, 1'b1, SW_EN ? 2'b10 : 2'b01);

    // Chip reset in the middle of SW_HOLD.
    swReq = 1'b1;
    tick();
    swReq = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("swHoldAbort", 1'b1, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0);
    runTable("afterSwAbort");

    // Random requests and occasional chip reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyStimulus(1'b1, 1'b0);
        repeat ($urandom_range(1, 3)) tick();
        applyStimulus(1'b0, 1'b0);
      end else begin
        swReq = ($urandom_range(0, 9) == 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
